// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, class and select encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    DP_EXEC,
    DP_WB,
    MEM_ADDR,
    ST_WRITE,
    LD_READ,
    LD_WB,
    BR
  } state_e;

  localparam logic [2:0] CLS_DP  = 3'b000;
  localparam logic [2:0] CLS_MEM = 3'b010;
  localparam logic [2:0] CLS_BR  = 3'b101;

  localparam logic [2:0] ALU_ADD = 3'b000;

  localparam logic [1:0] SRCB_ONE = 2'd0;
  localparam logic [1:0] SRCB_B   = 2'd1;
  localparam logic [1:0] SRCB_OP2 = 2'd2;
  localparam logic [1:0] SRCB_OFF = 2'd3;

  localparam logic [1:0] WD_MDR = 2'd0;
  localparam logic [1:0] WD_PC  = 2'd1;
  localparam logic [1:0] WD_ALU = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - selects the ALU operation: opcode pass-through or forced ADD
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [2:0] opc,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = alu_op ? opc : ALU_ADD;
  end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - Moore FSM sequencing fetch/decode/execute/memory/write-back
module controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Inst,
  input  logic [2:0] OPC,
  input  logic       I,
  input  logic       L_tr,
  input  logic       L_br,
  input  logic       D,
  input  logic       E,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RR2sel,
  output logic       WRsel,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic       PCsrc,
  output logic       flag_write,
  output logic       ALUop,
  output logic [1:0] ALUsrcB,
  output logic [1:0] WDsel,
  output logic [2:0] ALUctrl
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    IRWrite    = 1'b0;
    WRsel      = 1'b0;
    RegWrite   = 1'b0;
    ALUsrcA    = 1'b0;
    PCsrc      = 1'b0;
    flag_write = 1'b0;
    ALUop      = 1'b0;
    ALUsrcB    = SRCB_ONE;
    WDsel      = WD_MDR;
    RR2sel     = (Inst == CLS_DP) && !I;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        // branch target PC+1+offset lands in ALUreg for BR to use
        ALUsrcB = SRCB_OFF;
        if (!D)                   state_d = FETCH;
        else if (Inst == CLS_DP)  state_d = DP_EXEC;
        else if (Inst == CLS_MEM) state_d = MEM_ADDR;
        else if (Inst == CLS_BR)  state_d = BR;
        else                      state_d = FETCH;
      end
      DP_EXEC: begin
        ALUsrcA    = 1'b1;
        ALUsrcB    = I ? SRCB_OP2 : SRCB_B;
        ALUop      = 1'b1;
        flag_write = 1'b1;
        state_d    = E ? FETCH : DP_WB;
      end
      DP_WB: begin
        RegWrite = 1'b1;
        WDsel    = WD_ALU;
        state_d  = FETCH;
      end
      MEM_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_OP2;
        state_d = L_tr ? LD_READ : ST_WRITE;
      end
      ST_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = FETCH;
      end
      LD_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = LD_WB;
      end
      LD_WB: begin
        RegWrite = 1'b1;
        WDsel    = WD_MDR;
        state_d  = FETCH;
      end
      BR: begin
        // link writes the already-incremented PC into R15 on the same edge PC loads
        PCWrite = 1'b1;
        PCsrc   = 1'b1;
        if (L_br) begin
          RegWrite = 1'b1;
          WRsel    = 1'b1;
          WDsel    = WD_PC;
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      flag_write = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op   (ALUop),
    .opc      (OPC),
    .alu_ctrl (ALUctrl)
  );

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - self-checking bench for the multicycle controller
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] Inst, OPC;
  logic       I, L_tr, L_br, D, E;
  logic       PCWrite, IorD, MemWrite, MemRead, IRWrite, RR2sel, WRsel, RegWrite;
  logic       ALUsrcA, PCsrc, flag_write, ALUop;
  logic [1:0] ALUsrcB, WDsel;
  logic [2:0] ALUctrl;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       rr2sel;
    logic       wrsel;
    logic       reg_write;
    logic       srca;
    logic       pcsrc;
    logic       flag_write;
    logic       alu_op;
    logic [1:0] srcb;
    logic [1:0] wdsel;
    logic [2:0] alu_ctrl;
  } out_t;

  typedef struct {
    logic [2:0] inst;
    logic [2:0] opc;
    logic       i, ltr, lbr, d, e;
    int         cycles;
    string      name;
  } vec_t;

  out_t act;
  out_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  controller dut (
    .clk(clk), .rst(rst), .Inst(Inst), .OPC(OPC), .I(I), .L_tr(L_tr), .L_br(L_br),
    .D(D), .E(E), .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead),
    .IRWrite(IRWrite), .RR2sel(RR2sel), .WRsel(WRsel), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .PCsrc(PCsrc), .flag_write(flag_write), .ALUop(ALUop),
    .ALUsrcB(ALUsrcB), .WDsel(WDsel), .ALUctrl(ALUctrl)
  );

  assign act = {PCWrite, IorD, MemWrite, MemRead, IRWrite, RR2sel, WRsel, RegWrite,
                ALUsrcA, PCsrc, flag_write, ALUop, ALUsrcB, WDsel, ALUctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic out_t base(input logic [2:0] inst, input logic i);
    out_t o = '0;
    o.rr2sel = (inst == 3'b000) && !i;
    return o;
  endfunction

  // Reference: the per-cycle output list an instruction should produce, from FETCH onward.
  function automatic void build_seq(input vec_t v);
    out_t o;
    exp_q.delete();
    o = base(v.inst, v.i);
    o.mem_read = 1; o.ir_write = 1; o.pc_write = 1;
    exp_q.push_back(o);
    o = base(v.inst, v.i);
    o.srcb = 2'd3;
    exp_q.push_back(o);
    if (!v.d) return;
    if (v.inst == 3'b000) begin
      o = base(v.inst, v.i);
      o.srca = 1; o.srcb = v.i ? 2'd2 : 2'd1; o.alu_op = 1; o.flag_write = 1;
      o.alu_ctrl = v.opc;
      exp_q.push_back(o);
      if (!v.e) begin
        o = base(v.inst, v.i);
        o.reg_write = 1; o.wdsel = 2'd2;
        exp_q.push_back(o);
      end
    end else if (v.inst == 3'b010) begin
      o = base(v.inst, v.i);
      o.srca = 1; o.srcb = 2'd2;
      exp_q.push_back(o);
      o = base(v.inst, v.i);
      o.iord = 1;
      if (v.ltr) begin
        o.mem_read = 1;
        exp_q.push_back(o);
        o = base(v.inst, v.i);
        o.reg_write = 1; o.wdsel = 2'd0;
        exp_q.push_back(o);
      end else begin
        o.mem_write = 1;
        exp_q.push_back(o);
      end
    end else if (v.inst == 3'b101) begin
      o = base(v.inst, v.i);
      o.pc_write = 1; o.pcsrc = 1;
      if (v.lbr) begin
        o.reg_write = 1; o.wrsel = 1; o.wdsel = 2'd1;
      end
      exp_q.push_back(o);
    end
  endfunction

  task automatic drive(input vec_t v);
    Inst = v.inst; OPC = v.opc; I = v.i; L_tr = v.ltr; L_br = v.lbr; D = v.d; E = v.e;
  endtask

  // Starts in the instruction's FETCH cycle and checks every cycle against the reference.
  task automatic run_instr(input vec_t v, input bit sync);
    if (sync) @(negedge clk);
    drive(v);
    build_seq(v);
    foreach (exp_q[k]) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("%s c%0d", v.name, k), 32'(act), 32'(exp_q[k]));
    end
  endtask

  task automatic measure(input vec_t v);
    int cnt;
    @(negedge clk);
    drive(v);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!IRWrite && cnt < 10);
    chk({v.name, " cycles"}, 32'(cnt), 32'(v.cycles));
  endtask

  vec_t tbl[$];
  vec_t v;
  out_t fetch_o;

  initial begin
    rst = 1'b1;
    Inst = '0; OPC = '0; I = 0; L_tr = 0; L_br = 0; D = 0; E = 0;

    tbl.push_back('{3'b000, 3'b010, 1, 0, 0, 1, 0, 4, "dp_imm"});
    tbl.push_back('{3'b000, 3'b010, 1, 0, 0, 1, 1, 3, "tst"});
    tbl.push_back('{3'b000, 3'b110, 0, 0, 0, 1, 0, 4, "dp_reg"});
    tbl.push_back('{3'b010, 3'b000, 1, 1, 0, 1, 0, 5, "load"});
    tbl.push_back('{3'b010, 3'b000, 1, 0, 0, 1, 0, 4, "store"});
    tbl.push_back('{3'b101, 3'b000, 0, 0, 1, 1, 0, 3, "bl"});
    tbl.push_back('{3'b101, 3'b000, 0, 0, 0, 1, 0, 3, "b"});
    tbl.push_back('{3'b000, 3'b010, 1, 0, 0, 0, 0, 2, "cond_fail"});
    tbl.push_back('{3'b111, 3'b000, 0, 0, 0, 1, 0, 2, "nop"});

    // all enables low while reset is held
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_enables", 32'({PCWrite, MemWrite, MemRead, IRWrite, RegWrite, flag_write}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(tbl[0], 1'b0);

    foreach (tbl[n]) begin
      measure(tbl[n]);
      run_instr(tbl[n], 1'b1);
    end

    // reset asserted in DP_EXEC: no flag write, back to FETCH
    v = tbl[0];
    @(negedge clk);
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_flag", 32'(flag_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flag", 32'(flag_write), 32'd0);
    chk("mid_rst_enables", 32'({PCWrite, MemWrite, MemRead, IRWrite, RegWrite, flag_write}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    fetch_o = base(v.inst, v.i);
    fetch_o.mem_read = 1; fetch_o.ir_write = 1; fetch_o.pc_write = 1;
    chk("post_rst_fetch", 32'(act), 32'(fetch_o));

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: v.inst = 3'b000;
        1: v.inst = 3'b010;
        2: v.inst = 3'b101;
        default: v.inst = 3'($urandom_range(0, 7));
      endcase
      v.opc = 3'($urandom_range(0, 7));
      v.i   = 1'($urandom_range(0, 1));
      v.ltr = 1'($urandom_range(0, 1));
      v.lbr = 1'($urandom_range(0, 1));
      v.d   = ($urandom_range(0, 4) != 0);
      v.e   = 1'($urandom_range(0, 1));
      v.name = $sformatf("rnd%0d", r);
      run_instr(v, 1'b1);
    end

    @(negedge clk);
    #1;
    chk("final_fetch", 32'({MemRead, IRWrite, PCWrite}), 32'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
